sort_checker: RTL and testbench

Self-checking monitor at the output end of the parallel sorter (`top`). It records every input vector presented to the sorter and, after a fixed pipeline latency, compares it with the vector the sorter produces. Each result is checked for two properties: the output is non-decreasing, and the output is a permutation of the matching input. The block is synthesizable and sits beside the sorter in benches and on hardware. Its sticky flags, counters and first-failure capture make sorter faults visible without a waveform viewer.

---
 rtl/sort_checker.sv | 161 ++++++++++++++++
 tb/tb_sort_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_checker.sv
// sort_checker
// Monitor that sits at the output of the parallel sorter. Every vector that
// enters the sorter is delayed by the sorter latency and paired with the
// sorter output. Each pair is checked for ascending order and for multiset
// equality. Sticky flags, saturating counters and a first-failure snapshot
// keep faults visible without a waveform viewer.
//
// Parameters:
//   n   elements per vector
//   k   bits per element (unsigned)
//   LAT sorter latency in cycles (>= 1)
//   CW  width of check_cnt / err_cnt
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   in carries a vector to be checked
//   in         sorter input vector, element i at in[(i+1)*k-1 -: k]
//   out        sorter output vector, same layout
//   chk_valid  one-cycle pulse, a result is present
//   err_sort   with chk_valid: out is not non-decreasing
//   err_perm   with chk_valid: out is not a permutation of the input
//   err        sticky OR of all failures since reset
//   check_cnt  comparisons performed (saturating)
//   err_cnt    failing comparisons (saturating)
//   first_in   input vector of the first failing comparison
//   first_out  output vector of the first failing comparison
module sort_checker #(
  parameter int n   = 8,
  parameter int k   = 4,
  parameter int LAT = 8,
  parameter int CW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [n*k-1:0]  in,
  input  logic [n*k-1:0]  out,
  output logic            chk_valid,
  output logic            err_sort,
  output logic            err_perm,
  output logic            err,
  output logic [CW-1:0]   check_cnt,
  output logic [CW-1:0]   err_cnt,
  output logic [n*k-1:0]  first_in,
  output logic [n*k-1:0]  first_out
);

  // Histogram bins must hold a count of n, hence n+1 distinct values.
  localparam int BW = $clog2(n + 1);
  localparam int NB = 1 << k;

  function automatic logic order_bad(input logic [n*k-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < n - 1; i++) begin
      if (v[i*k +: k] > v[(i+1)*k +: k]) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic perm_bad(input logic [n*k-1:0] a,
                                    input logic [n*k-1:0] b);
    logic [BW-1:0] ha [NB];
    logic [BW-1:0] hb [NB];
    logic          bad;
    for (int v = 0; v < NB; v++) begin
      ha[v] = '0;
      hb[v] = '0;
    end
    for (int i = 0; i < n; i++) begin
      ha[a[i*k +: k]] = ha[a[i*k +: k]] + BW'(1);
      hb[b[i*k +: k]] = hb[b[i*k +: k]] + BW'(1);
    end
    bad = 1'b0;
    for (int v = 0; v < NB; v++) begin
      if (ha[v] != hb[v]) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  logic [LAT-1:0] r_dly_vld;
  logic [n*k-1:0] r_dly_data [LAT];

  logic           r_chk_valid;
  logic           r_err_sort;
  logic           r_err_perm;
  logic           r_err;
  logic [CW-1:0]  r_check_cnt;
  logic [CW-1:0]  r_err_cnt;
  logic [n*k-1:0] r_first_in;
  logic [n*k-1:0] r_first_out;

  logic           w_last_vld;
  logic [n*k-1:0] w_last_in;
  logic           w_srt_bad;
  logic           w_perm_bad;
  logic           w_fail;

  // ---- delay line: stage 0 samples the sorter input, LAT-1 meets out ----
  always_ff @(posedge clk) begin
    r_dly_data[0] <= in;
    for (int j = 1; j < LAT; j++) r_dly_data[j] <= r_dly_data[j-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dly_vld <= '0;
    end else begin
      r_dly_vld[0] <= in_valid;
      for (int j = 1; j < LAT; j++) r_dly_vld[j] <= r_dly_vld[j-1];
    end
  end

  assign w_last_vld = r_dly_vld[LAT-1];
  assign w_last_in  = r_dly_data[LAT-1];
  assign w_srt_bad  = order_bad(out);
  assign w_perm_bad = perm_bad(w_last_in, out);
  assign w_fail     = w_last_vld & (w_srt_bad | w_perm_bad);

  // ---- result register: checks of the paired vectors become visible ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_valid <= 1'b0;
      r_err_sort  <= 1'b0;
      r_err_perm  <= 1'b0;
      r_err       <= 1'b0;
      r_check_cnt <= '0;
      r_err_cnt   <= '0;
      r_first_in  <= '0;
      r_first_out <= '0;
    end else begin
      r_chk_valid <= w_last_vld;
      r_err_sort  <= w_last_vld & w_srt_bad;
      r_err_perm  <= w_last_vld & w_perm_bad;
      if (w_last_vld) r_check_cnt <= sat_inc(r_check_cnt);
      if (w_fail) begin
        r_err_cnt <= sat_inc(r_err_cnt);
        r_err     <= 1'b1;
        // Snapshot only the very first failure; r_err guards later ones.
        if (!r_err) begin
          r_first_in  <= w_last_in;
          r_first_out <= out;
        end
      end
    end
  end

  assign chk_valid = r_chk_valid;
  assign err_sort  = r_err_sort;
  assign err_perm  = r_err_perm;
  assign err       = r_err;
  assign check_cnt = r_check_cnt;
  assign err_cnt   = r_err_cnt;
  assign first_in  = r_first_in;
  assign first_out = r_first_out;

endmodule

// File: tb/tb_sort_checker.sv
module tb_sort_checker;
  localparam int N  = 8;
  localparam int K  = 4;
  localparam int L  = 8;
  localparam int NK = N * K;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [NK-1:0] in_v = '0;
  logic [NK-1:0] out_v = '0;

  logic          a_chk_valid, a_err_sort, a_err_perm, a_err;
  logic [15:0]   a_check_cnt, a_err_cnt;
  logic [NK-1:0] a_first_in, a_first_out;
  logic          b_chk_valid, b_err_sort, b_err_perm, b_err;
  logic [2:0]    b_check_cnt, b_err_cnt;
  logic [NK-1:0] b_first_in, b_first_out;

  sort_checker #(.n(N), .k(K), .LAT(L), .CW(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_v), .out(out_v),
    .chk_valid(a_chk_valid), .err_sort(a_err_sort), .err_perm(a_err_perm),
    .err(a_err), .check_cnt(a_check_cnt), .err_cnt(a_err_cnt),
    .first_in(a_first_in), .first_out(a_first_out));

  sort_checker #(.n(N), .k(K), .LAT(L), .CW(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_v), .out(out_v),
    .chk_valid(b_chk_valid), .err_sort(b_err_sort), .err_perm(b_err_perm),
    .err(b_err), .check_cnt(b_check_cnt), .err_cnt(b_err_cnt),
    .first_in(b_first_in), .first_out(b_first_out));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int            edge_no;
    logic          sb;
    logic          pb;
    logic [NK-1:0] iv;
    logic [NK-1:0] ov;
  } exp_t;
  exp_t sbq[$];
  logic [NK-1:0] out_at [int];

  // Reference state of the checker, rebuilt from popped expectations.
  int            m_chk = 0;
  int            m_err = 0;
  logic          m_flag = 1'b0;
  logic [NK-1:0] m_fin = '0;
  logic [NK-1:0] m_fout = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int elem(input logic [NK-1:0] v, input int i);
    logic [NK-1:0] t;
    t = v >> (i * K);
    return int'(t[K-1:0]);
  endfunction

  function automatic logic [NK-1:0] sorted(input logic [NK-1:0] v);
    int q[$];
    logic [NK-1:0] r;
    for (int i = 0; i < N; i++) q.push_back(elem(v, i));
    q.sort();
    r = '0;
    for (int i = 0; i < N; i++) r[i*K +: K] = K'(q[i]);
    return r;
  endfunction

  function automatic logic ref_sort_bad(input logic [NK-1:0] v);
    for (int i = 0; i < N - 1; i++)
      if (elem(v, i) > elem(v, i + 1)) return 1'b1;
    return 1'b0;
  endfunction

  // Two vectors hold the same multiset iff their sorted forms are equal.
  function automatic logic ref_perm_bad(input logic [NK-1:0] a, input logic [NK-1:0] b);
    return sorted(a) != sorted(b);
  endfunction

  function automatic int sat(input int x, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  // One cycle of stimulus; called at posedge+#1, inputs land on the next edge.
  task automatic step(input logic vld, input logic [NK-1:0] iv, input logic [NK-1:0] ov);
    int e;
    exp_t x;
    e = cyc + 1;
    in_valid = vld;
    in_v = iv;
    if (vld) begin
      out_at[e + L] = ov;
      x.edge_no = e;
      x.sb = ref_sort_bad(ov);
      x.pb = ref_perm_bad(iv, ov);
      x.iv = iv;
      x.ov = ov;
      sbq.push_back(x);
    end
    if (out_at.exists(e)) begin
      out_v = out_at[e];
      out_at.delete(e);
    end else begin
      out_v = {$urandom, $urandom};
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) step(1'b0, NK'($urandom), '0);
  endtask

  task automatic do_reset(input int c);
    rst = 1'b1;
    in_valid = 1'b0;
    sbq.delete();
    out_at.delete();
    m_chk = 0; m_err = 0; m_flag = 1'b0; m_fin = '0; m_fout = '0;
    repeat (c) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops expectations on every result pulse, checks all outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_chk_valid", {a_chk_valid, b_chk_valid}, 2'b00);
        check("rst_flags", {a_err_sort, a_err_perm, a_err, b_err}, 4'b0000);
        check("rst_cnt", {a_check_cnt, a_err_cnt, b_check_cnt, b_err_cnt}, '0);
        check("rst_first", {a_first_in, a_first_out}, '0);
      end else begin
        if (a_chk_valid) begin
          if (sbq.size() == 0) begin
            check("unexpected_chk", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("latency", cyc, e.edge_no + L);
            check("err_sort", a_err_sort, e.sb);
            check("err_perm", a_err_perm, e.pb);
            check("b_flags", {b_chk_valid, b_err_sort, b_err_perm}, {1'b1, e.sb, e.pb});
            m_chk++;
            if (e.sb | e.pb) begin
              m_err++;
              if (!m_flag) begin
                m_fin = e.iv;
                m_fout = e.ov;
              end
              m_flag = 1'b1;
            end
          end
        end else begin
          check("idle_flags", {a_err_sort, a_err_perm, b_chk_valid, b_err_sort, b_err_perm}, '0);
        end
        if (sbq.size() > 0 && cyc > sbq[0].edge_no + L) begin
          check("missed_chk", 0, 1);
          void'(sbq.pop_front());
        end
        check("a_check_cnt", a_check_cnt, sat(m_chk, 16));
        check("a_err_cnt", a_err_cnt, sat(m_err, 16));
        check("b_check_cnt", b_check_cnt, sat(m_chk, 3));
        check("b_err_cnt", b_err_cnt, sat(m_err, 3));
        check("err_sticky", {a_err, b_err}, {m_flag, m_flag});
        check("a_first", {a_first_in, a_first_out}, {m_fin, m_fout});
        check("b_first", {b_first_in, b_first_out}, {m_fin, m_fout});
      end
    end
  end

  initial begin
    logic [NK-1:0] v;
    logic [NK-1:0] w;
    do_reset(3);

    // Back-to-back correct vectors, first one on the first edge after release.
    for (int i = 0; i < 10; i++) begin
      v = NK'({$urandom, $urandom});
      step(1'b1, v, sorted(v));
    end
    idle(L + 2);
    check("ph2_cnt", {a_check_cnt, a_err_cnt, 15'd0, a_err}, {16'd10, 16'd0, 16'd0});

    // Order fault: permutation of the input with one adjacent pair swapped.
    step(1'b1, 32'h7544_0213, 32'h7544_2310);
    idle(L + 2);
    check("ph3_err", {a_err, a_err_cnt}, {1'b1, 16'd1});
    check("ph3_first", {a_first_in, a_first_out}, {32'h7544_0213, 32'h7544_2310});

    // Permutation fault, then one more failure; snapshot must stay put.
    step(1'b1, 32'h7654_3210, 32'h6654_3210);
    v = NK'($urandom);
    w = sorted(v);
    w[K-1:0] = w[K-1:0] ^ 4'h1;
    step(1'b1, v, w);
    idle(L + 2);
    check("ph4_cnt", a_err_cnt, 16'd3);
    check("ph4_first", {a_first_in, a_first_out}, {32'h7544_0213, 32'h7544_2310});

    // Gaps: fixed 1,0,1 then a random valid pattern with correct outputs.
    v = NK'($urandom); step(1'b1, v, sorted(v));
    step(1'b0, '0, '0);
    v = NK'($urandom); step(1'b1, v, sorted(v));
    for (int i = 0; i < 24; i++) begin
      v = NK'({$urandom, $urandom});
      step(1'($urandom_range(0, 1)), v, sorted(v));
    end
    idle(L + 2);

    // Reset with three vectors in flight; none may surface afterwards.
    for (int i = 0; i < 3; i++) begin
      v = NK'($urandom);
      step(1'b1, v, 32'h0000_0001);
    end
    do_reset(2);
    idle(L + 4);
    check("ph5_cnt", {a_check_cnt, a_err_cnt, a_err}, '0);

    // Nine failing vectors: CW=3 instance saturates at 7.
    for (int i = 0; i < 9; i++) begin
      v = NK'({$urandom, $urandom});
      w = sorted(v);
      w[K-1:0] = w[K-1:0] ^ 4'h1;
      step(1'b1, v, w);
    end
    idle(L + 2);
    check("ph6_b", {b_err_cnt, b_check_cnt, b_err}, {3'd7, 3'd7, 1'b1});
    check("ph6_a", {a_err_cnt, a_check_cnt}, {16'd9, 16'd9});
    check("drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
